multirate_counter: RTL and testbench
====================================

// Module: multirate_counter
// PURPOSE
//   Parametrised up/down counter advancing by 1 or 2 per clock, giving the
//   double-rate count of a dual-edge counter from a single rising-edge clock.
//   Programmable modulus (MAX_VAL), wrap or saturate mode, parallel load, a
//   terminal-count pulse and a sticky overflow flag. Used for rate-matched
//   counting and timebase generation in clocking/counter examples.
// PARAMETERS
//   WIDTH     4              counter width in bits (>=2)
//   MAX_VAL   (1<<WIDTH)-1   highest count value; range is 0..MAX_VAL (1 <= MAX_VAL <= 2^WIDTH-1)
//   SATURATE  0              0 = wrap modulo MAX_VAL+1; 1 = clamp at 0 / MAX_VAL
//   RST_VAL   0              value of cnt after reset (<= MAX_VAL)
// PORTS
//   clk       in   1      single clock, rising edge only
//   rst       in   1      synchronous, active-high reset
//   en        in   1      count enable
//   dbl       in   1      1 = step 2 per enabled cycle, 0 = step 1
//   up        in   1      1 = count up, 0 = count down
//   load      in   1      parallel load strobe
//   load_val  in   WIDTH  value loaded when load=1
//   clr_ovf   in   1      clears sticky ovf
//   cnt       out  WIDTH  current count (registered)
//   tc        out  1      terminal-count pulse (registered)
//   ovf       out  1      sticky overflow/underflow flag
// BEHAVIOUR
//   - All state updates on posedge clk. Priority: rst > load > en.
//   - Reset: cnt=RST_VAL, tc=0, ovf=0. Reset mid-count discards everything that cycle.
//   - load=1: cnt <= min(load_val, MAX_VAL); tc <= 0; ovf unchanged (clr_ovf still honoured).
//     Load overrides en in the same cycle.
//   - en=0 and load=0: cnt holds, tc <= 0.
//   - en=1: step = dbl ? 2 : 1; arithmetic in WIDTH+2 bits, no truncation before range check.
//     up:   n = cnt + step; out of range if n > MAX_VAL.
//     down: n = cnt - step; out of range if n < 0.
//     In range: cnt <= n, tc <= 0.
//     Out of range, SATURATE=0: up -> cnt <= n-(MAX_VAL+1); down -> cnt <= n+(MAX_VAL+1);
//       e.g. MAX_VAL=9, cnt=9, dbl=1, up -> cnt=1. tc <= 1.
//     Out of range, SATURATE=1: up -> cnt <= MAX_VAL; down -> cnt <= 0; tc <= 1.
//       tc keeps asserting every enabled cycle the counter is pinned against the bound.
//   - MAX_VAL=1 with dbl=1, wrap mode: cnt returns to the same value, tc=1 every enabled cycle.
//   - Latency: cnt and tc reflect the enabled cycle's inputs one clock later (same edge).
//   - ovf: set on any cycle that asserts tc; cleared by clr_ovf. Same-cycle set and clr -> ovf=1.
//   - dbl, up, en may change every cycle; no internal pipeline, no hidden state beyond cnt/tc/ovf.
// TESTING (WIDTH=4, MAX_VAL=9 unless noted)
//   1. rst=1 two cycles, RST_VAL=3 -> cnt=3, tc=0, ovf=0; release, en=1 up dbl=0 -> 4,5,...,9,0 with tc=1 only on 0.
//   2. en=1 up dbl=1 from 0 -> 2,4,6,8,0 (tc=1),2; from 9 -> 1 (tc=1); ovf=1 stays until clr_ovf.
//   3. Down dbl=1 from 1 -> 9 (tc=1); down dbl=0 from 0 -> 9 (tc=1); SATURATE=1 down from 1 dbl=1 -> 0, tc=1, then 0 held with tc=1 each cycle.
//   4. SATURATE=1 up dbl=1 from 8 -> 9 (tc=1); hold en -> cnt stays 9, tc=1 each cycle; en=0 -> tc=0.
//   5. load=1 load_val=15 with en=1 -> cnt=9 (clamped), tc=0; load and rst same cycle -> cnt=RST_VAL.
//   6. tc event and clr_ovf same cycle -> ovf=1; next cycle clr_ovf alone -> ovf=0; rst mid-count at cnt=7 -> cnt=RST_VAL next edge.

Source files
------------

// File: rtl/multirate_counter_if.sv
// Control/status bundle for multirate_counter: count controls in, count/flags out.
interface multirate_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             dbl;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clr_ovf;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             ovf;

  modport master (
    output en, dbl, up, load, load_val, clr_ovf,
    input  cnt, tc, ovf
  );

  modport slave (
    input  en, dbl, up, load, load_val, clr_ovf,
    output cnt, tc, ovf
  );
endinterface

// File: rtl/multirate_counter.sv
// Up/down modulo counter stepping 1 or 2 per rising edge, with wrap/saturate,
// parallel load, terminal-count pulse and sticky overflow.
module multirate_counter #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = (1 << WIDTH) - 1,
  parameter int SATURATE = 0,
  parameter int RST_VAL  = 0
) (
  input logic               clk,
  input logic               rst,
  multirate_counter_if.slave bus
);
  // Two guard bits: the up-sum never overflows and a down-borrow shows in the MSB.
  localparam int XW = WIDTH + 2;
  localparam logic [XW-1:0]    MAX_X = XW'(MAX_VAL);
  localparam logic [XW-1:0]    MOD_X = XW'(MAX_VAL + 1);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic [XW-1:0]    cnt_x, step_x, sum_x;
  logic             oor;

  always_comb begin
    cnt_d  = cnt_q;
    tc_d   = 1'b0;
    cnt_x  = XW'(cnt_q);
    step_x = bus.dbl ? XW'(2) : XW'(1);
    sum_x  = bus.up ? (cnt_x + step_x) : (cnt_x - step_x);
    oor    = bus.up ? (sum_x > MAX_X) : sum_x[XW-1];
    if (bus.load) begin
      cnt_d = (bus.load_val > MAX_W) ? MAX_W : bus.load_val;
    end else if (bus.en) begin
      tc_d = oor;
      if (!oor)              cnt_d = sum_x[WIDTH-1:0];
      else if (SATURATE != 0) cnt_d = bus.up ? MAX_W : '0;
      else if (bus.up)       cnt_d = WIDTH'(sum_x - MOD_X);
      else                   cnt_d = WIDTH'(sum_x + MOD_X);
    end
    // A fresh terminal count wins over a same-cycle clear.
    ovf_d = tc_d | (ovf_q & ~bus.clr_ovf);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RST_W;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.cnt = cnt_q;
  assign bus.tc  = tc_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_multirate_counter.sv
// Scoreboard bench: wrap (MAX 9, RST 3), saturate (MAX 9, RST 3) and wrap MAX 1
// counters share one stimulus stream; expectations come from a behavioural model.
module tb_multirate_counter;
  localparam int WIDTH = 4;
  localparam int ND = 3;
  localparam int MAXV [ND] = '{9, 9, 1};
  localparam int SATV [ND] = '{0, 1, 0};
  localparam int RSTV [ND] = '{3, 3, 0};

  typedef struct {
    string tag;
    int    cnt;
    bit    tc;
    bit    ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multirate_counter_if #(.WIDTH(WIDTH)) bw ();
  multirate_counter_if #(.WIDTH(WIDTH)) bs ();
  multirate_counter_if #(.WIDTH(WIDTH)) bm ();

  multirate_counter #(.WIDTH(WIDTH), .MAX_VAL(9), .SATURATE(0), .RST_VAL(3))
    u_wrap (.clk(clk), .rst(rst), .bus(bw));
  multirate_counter #(.WIDTH(WIDTH), .MAX_VAL(9), .SATURATE(1), .RST_VAL(3))
    u_sat  (.clk(clk), .rst(rst), .bus(bs));
  multirate_counter #(.WIDTH(WIDTH), .MAX_VAL(1), .SATURATE(0), .RST_VAL(0))
    u_m1   (.clk(clk), .rst(rst), .bus(bm));

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sbq[$];
  int   m_cnt [ND] = '{0, 0, 0};
  bit   m_tc  [ND] = '{0, 0, 0};
  bit   m_ovf [ND] = '{0, 0, 0};

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model(input int d, input bit r, input bit ld, input int lv,
                       input bit e, input bit db, input bit u, input bit cl);
    int n;
    if (r) begin
      m_cnt[d] = RSTV[d]; m_tc[d] = 0; m_ovf[d] = 0;
    end else begin
      if (ld) begin
        m_cnt[d] = (lv > MAXV[d]) ? MAXV[d] : lv;
        m_tc[d]  = 0;
      end else if (!e) begin
        m_tc[d] = 0;
      end else begin
        n = u ? m_cnt[d] + (db ? 2 : 1) : m_cnt[d] - (db ? 2 : 1);
        if (n > MAXV[d] || n < 0) begin
          m_tc[d] = 1;
          if (SATV[d] != 0) m_cnt[d] = u ? MAXV[d] : 0;
          else              m_cnt[d] = u ? n - (MAXV[d] + 1) : n + (MAXV[d] + 1);
        end else begin
          m_cnt[d] = n; m_tc[d] = 0;
        end
      end
      if (m_tc[d])  m_ovf[d] = 1;
      else if (cl)  m_ovf[d] = 0;
    end
  endtask

  // Drive one cycle, push expectations, then pop and compare after the edge.
  task automatic cyc(input string tag, input bit r, input bit ld, input int lv,
                     input bit e, input bit db, input bit u, input bit cl);
    exp_t x;
    int gc; bit gt; bit go;
    rst = r;
    bw.load = ld; bw.load_val = 4'(lv); bw.en = e; bw.dbl = db; bw.up = u; bw.clr_ovf = cl;
    bs.load = ld; bs.load_val = 4'(lv); bs.en = e; bs.dbl = db; bs.up = u; bs.clr_ovf = cl;
    bm.load = ld; bm.load_val = 4'(lv); bm.en = e; bm.dbl = db; bm.up = u; bm.clr_ovf = cl;
    for (int d = 0; d < ND; d++) begin
      model(d, r, ld, lv, e, db, u, cl);
      x.tag = $sformatf("%s/d%0d", tag, d);
      x.cnt = m_cnt[d]; x.tc = m_tc[d]; x.ovf = m_ovf[d];
      sbq.push_back(x);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      x = sbq.pop_front();
      case (d)
        0:       begin gc = int'(bw.cnt); gt = bw.tc; go = bw.ovf; end
        1:       begin gc = int'(bs.cnt); gt = bs.tc; go = bs.ovf; end
        default: begin gc = int'(bm.cnt); gt = bm.tc; go = bm.ovf; end
      endcase
      chk({x.tag, ".cnt"}, gc, x.cnt);
      chk({x.tag, ".tc"},  int'(gt), int'(x.tc));
      chk({x.tag, ".ovf"}, int'(go), int'(x.ovf));
    end
  endtask

  initial begin
    // reset two cycles, then count up by one through the wrap
    cyc("rst0", 1, 0, 0, 0, 0, 0, 0);
    cyc("rst1", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc("up1", 0, 0, 0, 1, 0, 1, 0);
    // double-rate up from 0, then wrap from 9
    cyc("ld0", 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc("up2", 0, 0, 0, 1, 1, 1, 0);
    cyc("ld9", 0, 1, 9, 0, 0, 0, 0);
    cyc("up2w", 0, 0, 0, 1, 1, 1, 0);
    cyc("idle", 0, 0, 0, 0, 1, 1, 0);
    cyc("idle", 0, 0, 0, 0, 0, 0, 0);
    cyc("clr", 0, 0, 0, 0, 0, 0, 1);
    // down wrap / saturate at zero
    cyc("ld1", 0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("dn2", 0, 0, 0, 1, 1, 0, 0);
    cyc("ld0b", 0, 1, 0, 0, 0, 0, 0);
    cyc("dn1", 0, 0, 0, 1, 0, 0, 0);
    // saturate at top, then release enable
    cyc("ld8", 0, 1, 8, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("up2s", 0, 0, 0, 1, 1, 1, 0);
    cyc("en0", 0, 0, 0, 0, 1, 1, 0);
    // load clamp over enable; reset beats load
    cyc("ld15", 0, 1, 15, 1, 1, 1, 0);
    cyc("ldrst", 1, 1, 15, 1, 1, 1, 0);
    // tc together with clr_ovf keeps ovf; clr alone drops it
    cyc("ld9b", 0, 1, 9, 0, 0, 0, 0);
    cyc("tcclr", 0, 0, 0, 1, 0, 1, 1);
    cyc("clr2", 0, 0, 0, 0, 0, 1, 1);
    // reset mid-count
    cyc("ld7", 0, 1, 7, 0, 0, 0, 0);
    cyc("cnt7", 0, 0, 0, 1, 0, 1, 0);
    cyc("rstmid", 1, 0, 0, 1, 0, 1, 0);
    // random traffic
    for (int i = 0; i < 400; i++)
      cyc("rnd", ($urandom_range(31) == 0), ($urandom_range(7) == 0), int'($urandom_range(15)),
          ($urandom_range(3) != 0), 1'($urandom_range(1)), 1'($urandom_range(1)),
          ($urandom_range(7) == 0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
